spi_tx_feeder: RTL and testbench

SPI_TX_FEEDER -- requirements
Module: spi_tx_feeder

---
 rtl/spi_tx_feeder_if.sv | 40 ++++
 rtl/spi_tx_feeder.sv | 182 ++++++++++++++++++
 tb/tb_spi_tx_feeder.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_tx_feeder_if.sv
// spi_tx_feeder_if
// ----------------
// Bundles the producer write port, the FIFO status flags and the byte/strobe
// pair that feeds the downstream SPI master (spi_final).
//
// Signals
//   wr_data  [7:0]          byte from the producer
//   wr_en                   write strobe, one byte per cycle while high
//   full                    FIFO holds DEPTH bytes
//   empty                   FIFO holds no bytes
//   level    [log2(DEPTH):0] number of bytes currently stored
//   data_in  [7:0]          byte presented to spi_final
//   data_av                 byte-valid strobe to spi_final
//
// Modports
//   master : producer / testbench side (drives wr_data, wr_en)
//   slave  : the feeder itself (drives status and the SPI-side pair)
interface spi_tx_feeder_if #(
    parameter int DEPTH = 8
) ();
    localparam int LW = $clog2(DEPTH) + 1;

    logic [7:0]    wr_data;
    logic          wr_en;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic [7:0]    data_in;
    logic          data_av;

    modport master (
        output wr_data, wr_en,
        input  full, empty, level, data_in, data_av
    );

    modport slave (
        input  wr_data, wr_en,
        output full, empty, level, data_in, data_av
    );
endinterface

// File: rtl/spi_tx_feeder.sv
// spi_tx_feeder
// -------------
// Byte FIFO that paces bytes out to a downstream SPI master. Each stored byte
// is popped into data_in and announced with data_av held high for
// FRAME_CYCLES cycles, followed by GAP_CYCLES cycles low, then one IDLE cycle
// before the next byte may be popped (FRAME_CYCLES+GAP_CYCLES+1 spacing).
//
// Parameters
//   DEPTH        FIFO depth in bytes (power of two, 2..64)
//   FRAME_CYCLES cycles data_av is held high per byte (>= 9)
//   GAP_CYCLES   cycles data_av is held low between bytes (>= 1)
//
// Ports
//   m_clk     single clock, all state updates on its rising edge
//   n_reset   asynchronous active-low reset
//   bus       spi_tx_feeder_if.slave (write port, status, data_in/data_av)
//   overflow  sticky dropped-write flag   (only with SPI_FEEDER_OVF_STATUS_EN)
//   ovf_clr   clears overflow             (only with SPI_FEEDER_OVF_STATUS_EN)
//
// Build option
//   SPI_FEEDER_OVF_STATUS_EN : when defined, adds the overflow/ovf_clr ports
//   and the sticky overflow flag. When undefined, writes to a full FIFO are
//   silently dropped.
module spi_tx_feeder #(
    parameter int DEPTH        = 8,
    parameter int FRAME_CYCLES = 15,
    parameter int GAP_CYCLES   = 1
) (
    input  logic             m_clk,
    input  logic             n_reset,
    spi_tx_feeder_if.slave   bus
`ifdef SPI_FEEDER_OVF_STATUS_EN
    ,
    output logic             overflow,
    input  logic             ovf_clr
`endif
);

    localparam int PW      = $clog2(DEPTH);
    localparam int LW      = PW + 1;
    localparam int MAX_CNT = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [LW-1:0]    FULL_LEVEL = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             data_av_q, av_next;
    logic [7:0]       data_in_q;

    logic [7:0]       mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level_q, level_next;
    logic             full_q, empty_q;

    logic             push, pop;

    // Full is judged on the registered flag, i.e. before any pop in the same
    // cycle, so a write into a full FIFO is dropped even if a byte leaves.
    assign push = bus.wr_en && !full_q;

    // Frame sequencer: decides when to pop and how long data_av stays up.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        av_next    = data_av_q;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty_q) begin
                    pop        = 1'b1;
                    av_next    = 1'b1;
                    cnt_next   = FRAME_LOAD;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (cnt == '0) begin
                    av_next    = 1'b0;
                    cnt_next   = GAP_LOAD;
                    state_next = GAP;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sequencer state, counter and the SPI-side output registers.
    always_ff @(posedge m_clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            cnt       <= '0;
            data_av_q <= 1'b0;
            data_in_q <= 8'h00;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            data_av_q <= av_next;
            if (pop) begin
                data_in_q <= mem[rd_ptr];
            end
        end
    end

    // Occupancy after this edge; a simultaneous push and pop cancel out.
    always_comb begin
        level_next = level_q;
        unique case ({push, pop})
            2'b10:   level_next = level_q + 1'b1;
            2'b01:   level_next = level_q - 1'b1;
            default: level_next = level_q;
        endcase
    end

    // Pointers and status flags; flags are derived from the same next level
    // so full, empty and level always agree.
    always_ff @(posedge m_clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level_q <= level_next;
            full_q  <= (level_next == FULL_LEVEL);
            empty_q <= (level_next == '0);
        end
    end

    // Storage array; contents need no reset because empty gates every read.
    always_ff @(posedge m_clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

`ifdef SPI_FEEDER_OVF_STATUS_EN
    // Sticky record of any dropped write; a new drop beats a clear.
    always_ff @(posedge m_clk or negedge n_reset) begin
        if (!n_reset) begin
            overflow <= 1'b0;
        end else if (bus.wr_en && full_q) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end
`endif

    assign bus.full    = full_q;
    assign bus.empty   = empty_q;
    assign bus.level   = level_q;
    assign bus.data_in = data_in_q;
    assign bus.data_av = data_av_q;

endmodule

// File: tb/tb_spi_tx_feeder.sv
// tb_spi_tx_feeder
// ----------------
// Self-checking bench for spi_tx_feeder. A queue-based reference model tracks
// stored bytes, the time until the next byte may leave and how long data_av
// stays high; DUT outputs are compared against it every cycle. Directed
// scenarios (single byte, burst, overflow, wrap-around stream, simultaneous
// push/pop, reset mid-frame) are followed by a randomized phase.
// Build option SPI_FEEDER_OVF_STATUS_EN also checks the overflow flag.
module tb_spi_tx_feeder;

    localparam int DEPTH = 8;
    localparam int FRAME = 15;
    localparam int GAP   = 1;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic m_clk = 1'b0;
    logic n_reset;

    spi_tx_feeder_if #(.DEPTH(DEPTH)) bus ();

`ifdef SPI_FEEDER_OVF_STATUS_EN
    logic overflow;
    logic ovf_clr;
`endif

    spi_tx_feeder #(
        .DEPTH       (DEPTH),
        .FRAME_CYCLES(FRAME),
        .GAP_CYCLES  (GAP)
    ) dut (
        .m_clk   (m_clk),
        .n_reset (n_reset),
        .bus     (bus)
`ifdef SPI_FEEDER_OVF_STATUS_EN
        ,
        .overflow(overflow),
        .ovf_clr (ovf_clr)
`endif
    );

    always #5 m_clk = ~m_clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0] model_q[$];
    int         busy;
    int         av_cnt;
    logic [7:0] exp_data;
    logic       exp_ovf;

    // Observation of emitted bytes (captured on data_av rising)
    logic [7:0] obs_q[$];
    logic       prev_av;
    int         max_level;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        busy     = 0;
        av_cnt   = 0;
        exp_data = 8'h00;
        exp_ovf  = 1'b0;
        prev_av  = 1'b0;
    endtask

    // One rising edge of the reference: a byte leaves when the previous one
    // has had its full frame+gap time; a write lands if the FIFO was not full.
    task automatic model_edge();
        bit do_pop;
        bit do_push;
        if (!n_reset) begin
            model_reset();
            return;
        end
        do_pop  = (busy == 0) && (model_q.size() > 0);
        do_push = bus.wr_en && (model_q.size() < DEPTH);
`ifdef SPI_FEEDER_OVF_STATUS_EN
        if (bus.wr_en && model_q.size() == DEPTH) exp_ovf = 1'b1;
        else if (ovf_clr)                         exp_ovf = 1'b0;
`endif
        if (busy > 0)   busy--;
        if (av_cnt > 0) av_cnt--;
        if (do_pop) begin
            exp_data = model_q.pop_front();
            busy     = FRAME + GAP;
            av_cnt   = FRAME;
        end
        if (do_push) model_q.push_back(bus.wr_data);
    endtask

    task automatic check_all();
        checkOutput("data_av", 32'(bus.data_av), 32'(av_cnt > 0));
        checkOutput("data_in", 32'(bus.data_in), 32'(exp_data));
        checkOutput("level",   32'(bus.level),   32'(model_q.size()));
        checkOutput("empty",   32'(bus.empty),   32'(model_q.size() == 0));
        checkOutput("full",    32'(bus.full),    32'(model_q.size() == DEPTH));
`ifdef SPI_FEEDER_OVF_STATUS_EN
        checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
`endif
    endtask

    // Drive one cycle of stimulus from a falling edge, advance the model on
    // the rising edge and check on the next falling edge.
    task automatic applyStimulus(input logic en, input logic [7:0] d);
        bus.wr_en   = en;
        bus.wr_data = d;
        @(posedge m_clk);
        model_edge();
        @(negedge m_clk);
        check_all();
        if (bus.data_av && !prev_av) obs_q.push_back(bus.data_in);
        prev_av = bus.data_av;
        if (int'(bus.level) > max_level) max_level = int'(bus.level);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((model_q.size() > 0 || busy > 0) && n < budget) begin
            applyStimulus(1'b0, 8'h00);
            n++;
        end
        checkOutput("drain_timeout", 32'(n < budget), 32'd1);
        applyStimulus(1'b0, 8'h00);
    endtask

    initial begin
        int next_byte;
        int n;
        int aa_seen;
        int high_cycles;

        n_reset     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
`ifdef SPI_FEEDER_OVF_STATUS_EN
        ovf_clr = 1'b0;
`endif
        model_reset();
        max_level = 0;

        // Reset state
        @(negedge m_clk);
        @(negedge m_clk);
        check_all();
        n_reset = 1'b1;

        // Single byte
        applyStimulus(1'b1, 8'd2);
        applyStimulus(1'b0, 8'h00);
        checkOutput("single_latency", 32'(bus.data_av), 32'd1);
        drain(100);
        checkOutput("single_byte", 32'(obs_q.size() == 1 && obs_q[0] == 8'd2), 32'd1);
        obs_q.delete();

        // Burst 2..9
        max_level = 0;
        for (int i = 2; i <= 9; i++) applyStimulus(1'b1, 8'(i));
        checkOutput("burst_peak", 32'(max_level), 32'd7);
        drain(400);
        checkOutput("burst_count", 32'(obs_q.size()), 32'd8);
        for (int i = 0; i < obs_q.size(); i++)
            checkOutput("burst_order", 32'(obs_q[i]), 32'(i + 2));
        obs_q.delete();

        // Overflow: fill, then write 8'hAA while full
        n = 0;
        while (!bus.full && n < 40) begin
            applyStimulus(1'b1, 8'(8'h30 + n));
            n++;
        end
        checkOutput("fill_timeout", 32'(bus.full), 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'hAA);
`ifdef SPI_FEEDER_OVF_STATUS_EN
        checkOutput("ovf_sticky", 32'(overflow), 32'd1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("ovf_held", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        applyStimulus(1'b0, 8'h00);
        ovf_clr = 1'b0;
        checkOutput("ovf_cleared", 32'(overflow), 32'd0);
`endif
        drain(400);
        aa_seen = 0;
        foreach (obs_q[i]) if (obs_q[i] == 8'hAA) aa_seen++;
        checkOutput("ovf_dropped", 32'(aa_seen), 32'd0);
        obs_q.delete();

        // Wrap-around stream 2..20 gated by full
        next_byte = 2;
        n = 0;
        while (next_byte <= 20 && n < 2000) begin
            if (!bus.full) begin
                applyStimulus(1'b1, 8'(next_byte));
                next_byte++;
            end else begin
                applyStimulus(1'b0, 8'h00);
            end
            n++;
        end
        checkOutput("stream_timeout", 32'(n < 2000), 32'd1);
        drain(600);
        checkOutput("stream_count", 32'(obs_q.size()), 32'd19);
        for (int i = 0; i < obs_q.size(); i++)
            checkOutput("stream_order", 32'(obs_q[i]), 32'(i + 2));
        obs_q.delete();

        // Simultaneous write and pop at level 1
        applyStimulus(1'b1, 8'h55);
        applyStimulus(1'b1, 8'h66);
        checkOutput("simul_level", 32'(bus.level), 32'd1);
        drain(100);
        checkOutput("simul_order",
                    32'(obs_q.size() == 2 && obs_q[0] == 8'h55 && obs_q[1] == 8'h66), 32'd1);
        obs_q.delete();

        // Reset mid-SEND with bytes queued
        applyStimulus(1'b1, 8'hC1);
        applyStimulus(1'b1, 8'hC2);
        applyStimulus(1'b1, 8'hC3);
        applyStimulus(1'b1, 8'hC4);
        high_cycles = 0;
        n = 0;
        while (high_cycles < 5 && n < 50) begin
            if (bus.data_av) high_cycles++;
            if (high_cycles < 5) applyStimulus(1'b0, 8'h00);
            n++;
        end
        checkOutput("send_timeout", 32'(high_cycles), 32'd5);
        #2;
        n_reset = 1'b0;
        model_reset();
        #1;
        checkOutput("rst_av",    32'(bus.data_av), 32'd0);
        checkOutput("rst_level", 32'(bus.level),   32'd0);
        checkOutput("rst_data",  32'(bus.data_in), 32'd0);
        checkOutput("rst_empty", 32'(bus.empty),   32'd1);
        @(negedge m_clk);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 8'h00);
        n_reset = 1'b1;
        obs_q.delete();
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 8'h00);
        checkOutput("rst_no_stale", 32'(obs_q.size()), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
`ifdef SPI_FEEDER_OVF_STATUS_EN
            ovf_clr = ($urandom_range(0, 15) == 0);
`endif
            applyStimulus(1'($urandom_range(0, 3) == 0), 8'($urandom));
        end
`ifdef SPI_FEEDER_OVF_STATUS_EN
        ovf_clr = 1'b0;
`endif
        drain(600);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
